seq_mag_cmp: RTL

Sequential, parametrised successor to the 4-bit cascadable magnitude comparator. It compares two operands of arbitrary length, delivered MSB-chunk-first as CHUNK_W-bit beats over a valid/ready stream. It carries LT/EQ/GT cascade state between beats and returns one registered LT/EQ/GT result per operand pair. It sits between operand-streaming datapath logic and a consumer that accepts results under backpressure.

---
 rtl/seq_mag_cmp_if.sv | 38 +++
 rtl/seq_mag_cmp.sv | 132 +++++++++++++
 2 files changed

// File: rtl/seq_mag_cmp_if.sv
// Beat/result stream bundle for seq_mag_cmp. The master modport streams operand
// beats and consumes results; the slave modport is the comparator side.
interface seq_mag_cmp_if #(
    parameter int CHUNK_W   = 4,
    parameter int MAX_BEATS = 8
);
    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    logic               in_valid_pad;
    logic               in_ready_pad;
    logic               in_last_pad;
    logic [CHUNK_W-1:0] a_pad;
    logic [CHUNK_W-1:0] b_pad;
    logic               cas_lt_pad;
    logic               cas_eq_pad;
    logic               cas_gt_pad;
    logic               out_valid_pad;
    logic               out_ready_pad;
    logic               lt_pad;
    logic               eq_pad;
    logic               gt_pad;
    logic [CNT_W-1:0]   beats_pad;
    logic               err_pad;

    modport master (
        output in_valid_pad, in_last_pad, a_pad, b_pad,
               cas_lt_pad, cas_eq_pad, cas_gt_pad, out_ready_pad,
        input  in_ready_pad, out_valid_pad, lt_pad, eq_pad, gt_pad,
               beats_pad, err_pad
    );

    modport slave (
        input  in_valid_pad, in_last_pad, a_pad, b_pad,
               cas_lt_pad, cas_eq_pad, cas_gt_pad, out_ready_pad,
        output in_ready_pad, out_valid_pad, lt_pad, eq_pad, gt_pad,
               beats_pad, err_pad
    );
endinterface

// File: rtl/seq_mag_cmp.sv
// Sequential MSB-chunk-first magnitude comparator with LT/EQ/GT cascade inputs.
// Optional SEQ_MAG_CMP_SIGNED_EN: first chunk compared as two's complement.
module seq_mag_cmp #(
    parameter int CHUNK_W   = 4,
    parameter int MAX_BEATS = 8
) (
    input  logic         clk_pad,
    input  logic         rst_pad,
    seq_mag_cmp_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_BEATS + 1);
`ifdef SEQ_MAG_CMP_SIGNED_EN
    localparam logic SIGNED_EN = 1'b1;
`else
    localparam logic SIGNED_EN = 1'b0;
`endif
    // Flipping the sign bit turns a two's-complement compare into an unsigned one.
    localparam logic [CHUNK_W-1:0] SIGN_MASK = CHUNK_W'(1'b1) << (CHUNK_W - 1);

    typedef enum logic [0:0] {ST_FIRST = 1'b0, ST_ACCUM = 1'b1} state_t;
    typedef enum logic [1:0] {REL_EQ = 2'd0, REL_LT = 2'd1, REL_GT = 2'd2} rel_t;

    function automatic rel_t cmp_chunk(input logic [CHUNK_W-1:0] a,
                                       input logic [CHUNK_W-1:0] b,
                                       input logic               first);
        logic [CHUNK_W-1:0] ak;
        logic [CHUNK_W-1:0] bk;
        rel_t               r;
        if (first && SIGNED_EN) begin
            ak = a ^ SIGN_MASK;
            bk = b ^ SIGN_MASK;
        end else begin
            ak = a;
            bk = b;
        end
        if (ak < bk)      r = REL_LT;
        else if (ak > bk) r = REL_GT;
        else              r = REL_EQ;
        return r;
    endfunction

    state_t           state_r, state_nxt_s;
    rel_t             rel_r, beat_rel_s, rel_new_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s, beats_r;
    logic [2:0]       cas_r, cas_use_s;
    logic             in_ready_s, beat_s, trunc_s, last_s, first_s;
    logic             res_lt_s, res_eq_s, res_gt_s;
    logic             out_valid_r, lt_r, eq_r, gt_r, err_r;

    assign in_ready_s = ~rst_pad & (~out_valid_r | bus.out_ready_pad);
    assign beat_s     = bus.in_valid_pad & in_ready_s;
    assign first_s    = (state_r == ST_FIRST);
    assign cnt_nxt_s  = first_s ? CNT_W'(1'b1) : cnt_r + CNT_W'(1'b1);
    assign trunc_s    = (cnt_nxt_s == CNT_W'(MAX_BEATS));
    assign last_s     = bus.in_last_pad | trunc_s;
    assign cas_use_s  = first_s ? {bus.cas_lt_pad, bus.cas_eq_pad, bus.cas_gt_pad} : cas_r;
    assign beat_rel_s = cmp_chunk(bus.a_pad, bus.b_pad, first_s);
    // Once a chunk differs the relation is frozen for the rest of the pair.
    assign rel_new_s  = (first_s || rel_r == REL_EQ) ? beat_rel_s : rel_r;

    // Decode the relation including the current beat into result flags.
    always_comb begin
        res_lt_s = 1'b0;
        res_eq_s = 1'b0;
        res_gt_s = 1'b0;
        case (rel_new_s)
            REL_LT:  res_lt_s = 1'b1;
            REL_GT:  res_gt_s = 1'b1;
            REL_EQ:  {res_lt_s, res_eq_s, res_gt_s} = cas_use_s;
            default: {res_lt_s, res_eq_s, res_gt_s} = 3'b000;
        endcase
    end

    // Next-state logic: FIRST -> ACCUM on a non-final beat, back to FIRST on the final one.
    always_comb begin
        state_nxt_s = state_r;
        if (beat_s) begin
            if (last_s) state_nxt_s = ST_FIRST;
            else        state_nxt_s = ST_ACCUM;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // State register.
    always_ff @(posedge clk_pad or posedge rst_pad) begin
        if (rst_pad) state_r <= ST_FIRST;
        else         state_r <= state_nxt_s;
    end

    // Per-pair accumulation: running relation, beat count and captured cascade.
    always_ff @(posedge clk_pad or posedge rst_pad) begin
        if (rst_pad) begin
            rel_r <= REL_EQ;
            cnt_r <= '0;
            cas_r <= 3'b000;
        end else if (beat_s) begin
            rel_r <= last_s ? REL_EQ : rel_new_s;
            cnt_r <= last_s ? CNT_W'(1'b0) : cnt_nxt_s;
            if (first_s) cas_r <= cas_use_s;
        end
    end

    // Result register: loads on the final beat, valid drops on consume, data holds.
    always_ff @(posedge clk_pad or posedge rst_pad) begin
        if (rst_pad) begin
            out_valid_r <= 1'b0;
            lt_r        <= 1'b0;
            eq_r        <= 1'b0;
            gt_r        <= 1'b0;
            beats_r     <= '0;
            err_r       <= 1'b0;
        end else if (beat_s && last_s) begin
            out_valid_r <= 1'b1;
            lt_r        <= res_lt_s;
            eq_r        <= res_eq_s;
            gt_r        <= res_gt_s;
            beats_r     <= cnt_nxt_s;
            err_r       <= trunc_s & ~bus.in_last_pad;
        end else if (bus.out_ready_pad) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.in_ready_pad  = in_ready_s;
    assign bus.out_valid_pad = out_valid_r;
    assign bus.lt_pad        = lt_r;
    assign bus.eq_pad        = eq_r;
    assign bus.gt_pad        = gt_r;
    assign bus.beats_pad     = beats_r;
    assign bus.err_pad       = err_r;
endmodule
